// File: rtl/psync_pkg.sv
// Shared constants and per-channel status type for the pulse-synchronizer receive side.
package psync_pkg;

  localparam int unsigned PSYNC_MIN_STAGES = 2;
  localparam int unsigned PSYNC_TOTAL_W    = 16;
  localparam int unsigned PSYNC_CNT_MAX_W  = 16;

  // Pending field sized for the widest supported CNT_W; bits above CNT_W stay zero.
  typedef struct packed {
    logic [PSYNC_CNT_MAX_W-1:0] pending;
    logic                       ovf;
  } psync_chan_status_t;

endpackage

// File: rtl/pulse_sync_rx_multi_chan.sv
// One receive channel: sync chain, edge detect, saturating pending counter, sticky ovf.
// Optional evt_total counter when PSYNC_RX_EVT_CNT_EN is defined.
module psync_rx_chan
  import psync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prime_done,
  input  logic             tgl,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             evt_pulse,
  output logic             evt_valid,
  output logic [CNT_W-1:0] pending,
  output logic             ovf
`ifdef PSYNC_RX_EVT_CNT_EN
  ,
  output logic [PSYNC_TOTAL_W-1:0] evt_total
`endif
);

  localparam logic [PSYNC_CNT_MAX_W-1:0] SAT =
    PSYNC_CNT_MAX_W'((64'd1 << CNT_W) - 64'd1);
  localparam logic [PSYNC_CNT_MAX_W-1:0] ONE = PSYNC_CNT_MAX_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist;
  logic                   det;
  logic                   pop;
  logic                   sat;
  psync_chan_status_t     st;

  always_comb begin
    evt_valid = (st.pending != '0);
    det       = prime_done & (sync_q[SYNC_STAGES-1] ^ hist);
    pop       = evt_valid & evt_ready;
    sat       = (st.pending == SAT);
    pending   = st.pending[CNT_W-1:0];
    ovf       = st.ovf;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= '0;
      hist      <= 1'b0;
      evt_pulse <= 1'b0;
      st        <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], tgl};
      hist      <= sync_q[SYNC_STAGES-1];
      evt_pulse <= det;
      if (det && !pop && !sat)
        st.pending <= st.pending + ONE;
      else if (pop && !det)
        st.pending <= st.pending - ONE;
      // A det that is dropped only counts as overflow when no pop frees a slot.
      st.ovf <= (det & sat & ~pop) | (st.ovf & ~ovf_clr);
    end
  end

`ifdef PSYNC_RX_EVT_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      evt_total <= '0;
    else if (det)
      evt_total <= evt_total + PSYNC_TOTAL_W'(1);
  end
`endif

endmodule

// File: rtl/pulse_sync_rx_multi.sv
// Multi-channel toggle pulse-synchronizer receiver; owns the shared priming counter.
// Optional per-channel evt_total output when PSYNC_RX_EVT_CNT_EN is defined.
module pulse_sync_rx_multi
  import psync_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       tgl_in,
  output logic                      sync_rdy,
  output logic [CHANNELS-1:0]       evt_pulse,
  output logic [CHANNELS-1:0]       evt_valid,
  input  logic [CHANNELS-1:0]       evt_ready,
  output logic [CHANNELS*CNT_W-1:0] pending,
  output logic [CHANNELS-1:0]       ovf,
  input  logic [CHANNELS-1:0]       ovf_clr
`ifdef PSYNC_RX_EVT_CNT_EN
  ,
  output logic [CHANNELS*PSYNC_TOTAL_W-1:0] evt_total
`endif
);

  if (SYNC_STAGES < PSYNC_MIN_STAGES) begin : g_bad_stages
    $error("pulse_sync_rx_multi: SYNC_STAGES must be >= 2");
  end
  if (CNT_W < 1 || CNT_W > PSYNC_CNT_MAX_W) begin : g_bad_cnt_w
    $error("pulse_sync_rx_multi: CNT_W must be 1..16");
  end

  localparam int unsigned PRIME_W = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(SYNC_STAGES);

  logic [PRIME_W-1:0] prime_cnt;

  // SYNC_STAGES+1 edges: fill the chain, then load hist from a settled last stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prime_cnt <= '0;
      sync_rdy  <= 1'b0;
    end else if (!sync_rdy) begin
      prime_cnt <= prime_cnt + PRIME_W'(1);
      if (prime_cnt == PRIME_LAST)
        sync_rdy <= 1'b1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    psync_rx_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .prime_done(sync_rdy),
      .tgl       (tgl_in[c]),
      .evt_ready (evt_ready[c]),
      .ovf_clr   (ovf_clr[c]),
      .evt_pulse (evt_pulse[c]),
      .evt_valid (evt_valid[c]),
      .pending   (pending[c*CNT_W +: CNT_W]),
      .ovf       (ovf[c])
`ifdef PSYNC_RX_EVT_CNT_EN
      ,
      .evt_total (evt_total[c*PSYNC_TOTAL_W +: PSYNC_TOTAL_W])
`endif
    );
  end

endmodule
